// File: rtl/l2_l1_refill_tx.sv
// L2-side transmitter for L1 instruction refills.
// Takes a line request from L1 and looks it up in L2. On a hit it returns the L2 line.
// On a miss it fetches the line from memory in MBUS-wide beats, returns it to L1,
// and offers the same line to L2 for a fill.
module l2_l1_refill_tx #(
  parameter int TNUM   = 21,
  parameter int INUM   = 26 - TNUM,
  parameter int L21BUS = 512,
  parameter int MBUS   = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_L1_L2,
  input  logic [TNUM-1:0]        tag_L1_L2,
  input  logic [INUM-1:0]        index_L1_L2,
  output logic                   busy_L2_L1,
  output logic                   ready_L2_L1,
  output logic [L21BUS-1:0]      read_data_L2_L1,
  output logic                   lkp_req,
  output logic [TNUM+INUM-1:0]   lkp_addr,
  input  logic                   lkp_valid,
  input  logic                   lkp_hit,
  input  logic [L21BUS-1:0]      lkp_data,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic                   mem_rvalid,
  input  logic [MBUS-1:0]        mem_rdata,
  output logic                   fill_L2,
  output logic [L21BUS-1:0]      fill_data
);

  localparam int BEATS = L21BUS / MBUS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_BEAT,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TNUM-1:0]   tag_q;
  logic [INUM-1:0]   idx_q;
  logic [L21BUS-1:0] line;
  logic [CW-1:0]     cnt;
  logic              miss;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Handshake inputs matter only in the state that waits on them.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_L1_L2) state_nxt = LOOKUP;
      LOOKUP:   if (lkp_valid) state_nxt = lkp_hit ? RESP : MEM_REQ;
      MEM_REQ:  if (mem_ack) state_nxt = MEM_BEAT;
      MEM_BEAT: if (mem_rvalid && (cnt == LAST_BEAT)) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request latch, line assembly, beat counter and miss flag.
  // A single line register is both the L1 response and the L2 fill source.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      idx_q <= '0;
      line  <= '0;
      cnt   <= '0;
      miss  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_L1_L2) begin
            tag_q <= tag_L1_L2;
            idx_q <= index_L1_L2;
            miss  <= 1'b0;
          end
        end
        LOOKUP: begin
          if (lkp_valid && lkp_hit) begin
            line <= lkp_data;
            miss <= 1'b0;
          end
        end
        MEM_REQ: begin
          if (mem_ack) cnt <= '0;
        end
        MEM_BEAT: begin
          if (mem_rvalid) begin
            // Beats arrive lowest address first, so beat 0 lands in the low bits.
            line[int'(cnt)*MBUS +: MBUS] <= mem_rdata;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) miss <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_L2_L1      = (state != IDLE);
  assign ready_L2_L1     = (state == RESP);
  assign fill_L2         = (state == RESP) && miss;
  assign lkp_req         = (state == LOOKUP);
  assign mem_req         = (state == MEM_REQ);
  assign lkp_addr        = {tag_q, idx_q};
  assign mem_addr        = {tag_q, idx_q, 6'b0};
  assign read_data_L2_L1 = line;
  assign fill_data       = line;

endmodule

// File: tb/tb_l2_l1_refill_tx.sv
// Scoreboard bench for l2_l1_refill_tx: L2 and memory responders are driven by tasks.
module tb_l2_l1_refill_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_L1_L2;
  logic [20:0]  tag_L1_L2;
  logic [4:0]   index_L1_L2;
  logic         busy_L2_L1, ready_L2_L1;
  logic [511:0] read_data_L2_L1;
  logic         lkp_req;
  logic [25:0]  lkp_addr;
  logic         lkp_valid, lkp_hit;
  logic [511:0] lkp_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack, mem_rvalid;
  logic [127:0] mem_rdata;
  logic         fill_L2;
  logic [511:0] fill_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [511:0] exp_line[$];
  logic         exp_fill[$];
  logic [511:0] last_line = '0;
  logic [20:0]  rtag[32];
  logic [4:0]   ridx[32];

  l2_l1_refill_tx dut (
    .clk(clk), .rst(rst),
    .req_L1_L2(req_L1_L2), .tag_L1_L2(tag_L1_L2), .index_L1_L2(index_L1_L2),
    .busy_L2_L1(busy_L2_L1), .ready_L2_L1(ready_L2_L1), .read_data_L2_L1(read_data_L2_L1),
    .lkp_req(lkp_req), .lkp_addr(lkp_addr), .lkp_valid(lkp_valid), .lkp_hit(lkp_hit),
    .lkp_data(lkp_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fill_L2(fill_L2), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Monitor: each ready pulse pops the scoreboard. Outside ready, fill_L2 must stay low and
  // the returned line must not move except while a miss line is being assembled.
  always @(negedge clk) begin
    if (rst) begin
      last_line = read_data_L2_L1;
    end else if (ready_L2_L1) begin
      if (exp_line.size() == 0) begin
        check("unexpected_ready", ready_L2_L1, 1'b0);
      end else begin
        check("ret_line", read_data_L2_L1, exp_line.pop_front());
        check("ret_fill", fill_L2, exp_fill.pop_front());
        check("fill_data", fill_data, read_data_L2_L1);
      end
      last_line = read_data_L2_L1;
    end else begin
      if (fill_L2) check("stray_fill", fill_L2, 1'b0);
      if (!busy_L2_L1 || lkp_req || mem_req) begin
        if (read_data_L2_L1 !== last_line) check("line_stable", read_data_L2_L1, last_line);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One full request: L2 answers after ldly cycles; on a miss memory acks after adly
  // cycles and sends four beats separated by gap idle cycles. Returns in the RESP cycle.
  task automatic do_req(input logic [20:0] t, input logic [4:0] ix, input bit hit,
                        input logic [511:0] ln, input int ldly, input int adly, input int gap);
    cyc(1);
    req_L1_L2 = 1'b1; tag_L1_L2 = t; index_L1_L2 = ix;
    exp_line.push_back(ln); exp_fill.push_back(!hit);
    cyc(1);
    req_L1_L2 = 1'b0;
    check("busy", busy_L2_L1, 1'b1);
    check("lkp_req", lkp_req, 1'b1);
    check("lkp_addr", lkp_addr, {t, ix});
    cyc(ldly);
    lkp_valid = 1'b1; lkp_hit = hit; lkp_data = hit ? ln : ~ln;
    cyc(1);
    lkp_valid = 1'b0; lkp_hit = 1'b0;
    if (hit) begin
      check("hit_ready", ready_L2_L1, 1'b1);
      check("hit_fill", fill_L2, 1'b0);
    end else begin
      check("lkp_req_drop", lkp_req, 1'b0);
      check("mem_req", mem_req, 1'b1);
      check("mem_addr", mem_addr, {t, ix, 6'b0});
      cyc(adly);
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      check("mem_req_drop", mem_req, 1'b0);
      for (int b = 0; b < 4; b++) begin
        cyc(gap);
        mem_rvalid = 1'b1; mem_rdata = ln[b*128 +: 128];
        cyc(1);
        mem_rvalid = 1'b0;
        if (b < 3) check("early_ready", ready_L2_L1, 1'b0);
      end
      check("miss_ready", ready_L2_L1, 1'b1);
      check("miss_fill", fill_L2, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] la, lb;
    rst = 1'b1; req_L1_L2 = 1'b0; tag_L1_L2 = '0; index_L1_L2 = '0;
    lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_data = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cyc(3);
    check("rst_busy", busy_L2_L1, 1'b0);
    check("rst_ready", ready_L2_L1, 1'b0);
    check("rst_lkp_req", lkp_req, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_data", read_data_L2_L1, '0);
    rst = 1'b0;

    // T1: reset in the middle of a miss beat sequence.
    cyc(1);
    req_L1_L2 = 1'b1; tag_L1_L2 = 21'h1F0F0; index_L1_L2 = 5'd9;
    cyc(1);
    req_L1_L2 = 1'b0; lkp_valid = 1'b1; lkp_hit = 1'b0;
    cyc(1);
    lkp_valid = 1'b0; mem_ack = 1'b1;
    cyc(1);
    mem_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1; mem_rdata = {4{32'hDEAD0000 + b}};
      cyc(1);
    end
    mem_rvalid = 1'b0;
    rst = 1'b1;
    cyc(5);
    check("t1_busy", busy_L2_L1, 1'b0);
    check("t1_ready", ready_L2_L1, 1'b0);
    check("t1_fill", fill_L2, 1'b0);
    check("t1_mem_req", mem_req, 1'b0);
    check("t1_lkp_addr", lkp_addr, '0);
    check("t1_mem_addr", mem_addr, '0);
    check("t1_data", read_data_L2_L1, '0);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = {4{32'hBAD0BAD0}};
    cyc(2);
    mem_rvalid = 1'b0;
    cyc(6);
    check("t1_idle", busy_L2_L1, 1'b0);

    // T2: L2 hit with pattern A.
    for (int i = 0; i < 16; i++) la[i*32 +: 32] = 32'hA5A50000 + i;
    do_req(21'h0ABCD, 5'd3, 1'b1, la, 0, 0, 0);

    // T3: miss, ack after 3 cycles, beats 0..3 replicated with a gap.
    lb = {{4{32'd3}}, {4{32'd2}}, {4{32'd1}}, {4{32'd0}}};
    do_req(21'h12345, 5'd17, 1'b0, lb, 1, 3, 1);

    // T4: strays in IDLE are ignored.
    cyc(1);
    lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_data = ~la;
    mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = '1;
    cyc(3);
    check("t4_stray_busy", busy_L2_L1, 1'b0);
    check("t4_stray_data", read_data_L2_L1, lb);
    lkp_valid = 1'b0; lkp_hit = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    // Second request while busy is dropped.
    req_L1_L2 = 1'b1; tag_L1_L2 = 21'h00001; index_L1_L2 = 5'd1;
    exp_line.push_back(la ^ lb); exp_fill.push_back(1'b0);
    cyc(1);
    tag_L1_L2 = 21'h00002; index_L1_L2 = 5'd2;
    cyc(1);
    req_L1_L2 = 1'b0;
    check("t4_addr_kept", lkp_addr, {21'h00001, 5'd1});
    lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_data = la ^ lb;
    cyc(1);
    lkp_valid = 1'b0; lkp_hit = 1'b0;
    check("t4_ready", ready_L2_L1, 1'b1);
    // A request coincident with ready is dropped.
    req_L1_L2 = 1'b1; tag_L1_L2 = 21'h00003;
    cyc(1);
    req_L1_L2 = 1'b0;
    check("t4_ready_drop", busy_L2_L1, 1'b0);
    cyc(3);
    check("t4_still_idle", busy_L2_L1, 1'b0);

    // T5: random hits, then misses on the same addresses.
    for (int i = 0; i < 32; i++) begin
      rtag[i] = 21'($urandom); ridx[i] = 5'($urandom);
      do_req(rtag[i], ridx[i], 1'b1, rand_line(), $urandom_range(0, 2), 0, 0);
    end
    for (int i = 0; i < 32; i++)
      do_req(rtag[i], ridx[i], 1'b0, rand_line(), $urandom_range(0, 2),
             $urandom_range(0, 3), $urandom_range(0, 2));
    cyc(4);
    check("pending", 512'(exp_line.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
